// File: rtl/sprite_engine.sv
// Frame-synchronous sprite mover: each frame_clk tick moves every sprite by one step.
// Per frame: IDLE (wait for tick) -> UPDATE (one sprite per Clk) -> CHECK (collisions vs selected sprite).
`timescale 1ns/1ps
module sprite_engine #(
   parameter int NUM_SPRITES = 4,
   parameter int COORD_W     = 10,
   parameter int X_MAX       = 639,
   parameter int Y_MAX       = 479,
   parameter int SIZE        = 4,
   parameter int STEP        = 1,
   localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           frame_clk,
   input  logic [7:0]                     keycode,
   input  logic [SEL_W-1:0]               sel,
   output logic [NUM_SPRITES*COORD_W-1:0] SpriteX,
   output logic [NUM_SPRITES*COORD_W-1:0] SpriteY,
   output logic [COORD_W-1:0]             SpriteS,
   output logic [NUM_SPRITES-1:0]         hit,
   output logic [7:0]                     hit_count,
   output logic                           busy
);

   localparam int SW = COORD_W + 2;
   localparam int MW = COORD_W + 1;
   localparam logic [SEL_W-1:0]        LAST   = SEL_W'(NUM_SPRITES - 1);
   localparam logic [SW-1:0]           P_SIZE = SW'(SIZE);
   localparam logic [SW-1:0]           P_XMAX = SW'(X_MAX);
   localparam logic [SW-1:0]           P_YMAX = SW'(Y_MAX);
   localparam logic [SW-1:0]           P_HIT  = SW'(2 * SIZE);
   localparam logic signed [COORD_W:0] P_STEP = MW'(STEP);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_CHECK} state_t;

   state_t                    r_state, w_state_nxt;
   logic                      r_fc_meta, r_fc_sync, r_fc_prev;
   logic                      w_tick;
   logic [7:0]                r_key;
   logic [SEL_W-1:0]          r_sel;
   logic                      r_sel_ok;
   logic [SEL_W-1:0]          r_idx;
   logic [COORD_W-1:0]        r_x  [NUM_SPRITES];
   logic [COORD_W-1:0]        r_y  [NUM_SPRITES];
   logic signed [COORD_W:0]   r_mx [NUM_SPRITES];
   logic signed [COORD_W:0]   r_my [NUM_SPRITES];
   logic [NUM_SPRITES-1:0]    r_hit;
   logic [7:0]                r_hit_count;

   logic signed [COORD_W:0]   w_mx_key, w_my_key, w_mx_new, w_my_new;
   logic [COORD_W-1:0]        w_x_new, w_y_new;
   logic [NUM_SPRITES-1:0]    w_hit;

   // Reverse the motion when the sprite edge touches the border while moving into it.
   function automatic logic signed [COORD_W:0] bounce(
      input logic [COORD_W-1:0]    p,
      input logic signed [COORD_W:0] m,
      input logic [SW-1:0]         pmax
   );
      logic [SW-1:0] pe;
      logic          m_pos, m_neg;
      pe    = {2'b00, p};
      m_neg = m[COORD_W];
      m_pos = !m[COORD_W] && (m != '0);
      if ((pe + P_SIZE >= pmax) && m_pos) return -P_STEP;
      if ((pe <= P_SIZE) && m_neg)         return P_STEP;
      return m;
   endfunction

   function automatic logic [COORD_W-1:0] advance(
      input logic [COORD_W-1:0]    p,
      input logic signed [COORD_W:0] m,
      input logic [SW-1:0]         pmax
   );
      logic signed [SW-1:0] s;
      s = $signed({2'b00, p}) + $signed({m[COORD_W], m});
      if (s[SW-1])            return '0;
      if ($unsigned(s) > pmax) return pmax[COORD_W-1:0];
      return s[COORD_W-1:0];
   endfunction

   assign w_tick  = r_fc_sync & ~r_fc_prev;
   assign busy    = (r_state != S_IDLE);
   assign SpriteS = COORD_W'(SIZE);
   assign hit       = r_hit;
   assign hit_count = r_hit_count;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (w_tick) w_state_nxt = S_UPDATE;
         S_UPDATE: if (r_idx == LAST) w_state_nxt = S_CHECK;
         S_CHECK:  w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_mx_key = r_mx[r_idx];
      w_my_key = r_my[r_idx];
      if (r_sel_ok && (r_idx == r_sel)) begin
         case (r_key)
            8'h1A:   begin w_mx_key = '0;      w_my_key = -P_STEP; end
            8'h16:   begin w_mx_key = '0;      w_my_key = P_STEP;  end
            8'h04:   begin w_mx_key = -P_STEP; w_my_key = '0;      end
            8'h07:   begin w_mx_key = P_STEP;  w_my_key = '0;      end
            default: ;
         endcase
      end
      w_mx_new = bounce(r_x[r_idx], w_mx_key, P_XMAX);
      w_my_new = bounce(r_y[r_idx], w_my_key, P_YMAX);
      w_x_new  = advance(r_x[r_idx], w_mx_new, P_XMAX);
      w_y_new  = advance(r_y[r_idx], w_my_new, P_YMAX);
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
      logic [COORD_W-1:0] w_dx, w_dy;
      assign w_dx = (r_x[g] >= r_x[r_sel]) ? (r_x[g] - r_x[r_sel]) : (r_x[r_sel] - r_x[g]);
      assign w_dy = (r_y[g] >= r_y[r_sel]) ? (r_y[g] - r_y[r_sel]) : (r_y[r_sel] - r_y[g]);
      assign w_hit[g] = r_sel_ok && (SEL_W'(g) != r_sel) &&
                        ({2'b00, w_dx} <= P_HIT) && ({2'b00, w_dy} <= P_HIT);
      assign SpriteX[g*COORD_W +: COORD_W] = r_x[g];
      assign SpriteY[g*COORD_W +: COORD_W] = r_y[g];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_fc_meta   <= 1'b0;
         r_fc_sync   <= 1'b0;
         r_fc_prev   <= 1'b0;
         r_key       <= '0;
         r_sel       <= '0;
         r_sel_ok    <= 1'b0;
         r_idx       <= '0;
         r_hit       <= '0;
         r_hit_count <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_x[i]  <= COORD_W'(64 * (i + 1));
            r_y[i]  <= COORD_W'(240);
            r_mx[i] <= '0;
            r_my[i] <= '0;
         end
      end else begin
         r_fc_meta <= frame_clk;
         r_fc_sync <= r_fc_meta;
         r_fc_prev <= r_fc_sync;
         case (r_state)
            S_IDLE: begin
               if (w_tick) begin
                  r_key    <= keycode;
                  r_sel    <= sel;
                  r_sel_ok <= (int'(sel) < NUM_SPRITES);
                  r_idx    <= '0;
               end
            end
            S_UPDATE: begin
               r_mx[r_idx] <= w_mx_new;
               r_my[r_idx] <= w_my_new;
               r_x[r_idx]  <= w_x_new;
               r_y[r_idx]  <= w_y_new;
               r_idx       <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
            end
            S_CHECK: begin
               r_hit <= w_hit;
               // Count only the onset of a collision, not every frame it persists.
               if ((|w_hit) && !(|r_hit) && (r_hit_count != 8'hFF))
                  r_hit_count <= r_hit_count + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: hand-derived frame table, frame-level reference model and
// a scoreboard queue popped when each frame's busy window closes.
`timescale 1ns/1ps
module tb_sprite_engine;
   localparam int XM = 639;
   localparam int YM = 479;
   localparam int SZ = 4;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk = 1'b0;
   logic [7:0]  keycode = 8'h00;
   logic [1:0]  sel = 2'd0;
   logic [39:0] SpriteX, SpriteY;
   logic [9:0]  SpriteS;
   logic [3:0]  hit;
   logic [7:0]  hit_count;
   logic        busy;

   always #5 Clk = ~Clk;

   sprite_engine dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .sel(sel),
      .SpriteX(SpriteX), .SpriteY(SpriteY), .SpriteS(SpriteS), .hit(hit),
      .hit_count(hit_count), .busy(busy)
   );

   typedef struct packed {
      logic [39:0] sx;
      logic [39:0] sy;
      logic [3:0]  hit;
      logic [7:0]  hc;
   } exp_t;

   typedef struct {
      logic [7:0] key;
      logic [1:0] s;
      exp_t       e;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[6];
   int   n_cmp = 0;
   int   n_bad = 0;

   int   m_x[4], m_y[4], m_mx[4], m_my[4], m_hc;
   logic [3:0] m_hit;

   function automatic logic [39:0] pack4(input int a, input int b, input int c, input int d);
      return {10'(d), 10'(c), 10'(b), 10'(a)};
   endfunction

   function automatic vec_t mk(input logic [7:0] k, input logic [1:0] s,
                               input logic [39:0] sx, input logic [39:0] sy,
                               input logic [3:0] h, input logic [7:0] hc);
      vec_t v;
      v.key = k; v.s = s; v.e.sx = sx; v.e.sy = sy; v.e.hit = h; v.e.hc = hc;
      return v;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_x[i] = 64 * (i + 1); m_y[i] = 240; m_mx[i] = 0; m_my[i] = 0;
      end
      m_hc = 0; m_hit = 4'b0;
   endfunction

   function automatic exp_t model_frame(input int k, input int s);
      exp_t e;
      logic [3:0] h;
      for (int i = 0; i < 4; i++) begin
         if (i == s) begin
            case (k)
               'h1A: begin m_mx[i] = 0;  m_my[i] = -1; end
               'h16: begin m_mx[i] = 0;  m_my[i] = 1;  end
               'h04: begin m_mx[i] = -1; m_my[i] = 0;  end
               'h07: begin m_mx[i] = 1;  m_my[i] = 0;  end
               default: ;
            endcase
         end
         if (m_y[i] + SZ >= YM && m_my[i] > 0) m_my[i] = -1;
         if (m_y[i] <= SZ && m_my[i] < 0)      m_my[i] = 1;
         if (m_x[i] + SZ >= XM && m_mx[i] > 0) m_mx[i] = -1;
         if (m_x[i] <= SZ && m_mx[i] < 0)      m_mx[i] = 1;
         m_x[i] = m_x[i] + m_mx[i];
         m_y[i] = m_y[i] + m_my[i];
         if (m_x[i] < 0) m_x[i] = 0;
         if (m_x[i] > XM) m_x[i] = XM;
         if (m_y[i] < 0) m_y[i] = 0;
         if (m_y[i] > YM) m_y[i] = YM;
      end
      h = 4'b0;
      for (int i = 0; i < 4; i++)
         h[i] = (i != s) && (iabs(m_x[i] - m_x[s]) <= 2 * SZ) && (iabs(m_y[i] - m_y[s]) <= 2 * SZ);
      if (h != 4'b0 && m_hit == 4'b0 && m_hc < 255) m_hc++;
      m_hit = h;
      e.sx = pack4(m_x[0], m_x[1], m_x[2], m_x[3]);
      e.sy = pack4(m_y[0], m_y[1], m_y[2], m_y[3]);
      e.hit = h;
      e.hc = 8'(m_hc);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_output();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard: frame completed with no expectation queued");
      end else begin
         e = sb_q.pop_front();
         chk("spritex", SpriteX, e.sx);
         chk("spritey", SpriteY, e.sy);
         chk("hit", hit, e.hit);
         chk("hit_count", hit_count, e.hc);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      model_reset();
   endtask

   // One frame; inputs are scrambled once busy is seen to show they were latched.
   task automatic send_frame(input logic [7:0] k, input logic [1:0] s, input exp_t e);
      int n;
      keycode = k;
      sel = s;
      sb_q.push_back(e);
      @(negedge Clk);
      frame_clk = 1'b1;
      n = 0;
      while (!busy && n < 20) begin @(negedge Clk); n++; end
      chk("busy_rise", busy, 1);
      keycode = (k == 8'h1A) ? 8'h16 : 8'h1A;
      sel = ~s;
      n = 0;
      while (busy && n < 40) begin @(negedge Clk); n++; end
      chk("busy_len", n, 5);
      check_output();
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, extra, y_prev, y_cur, y_max;

      tbl[0] = mk(8'h07, 2'd0, pack4(65,128,192,256), pack4(240,240,240,240), 4'b0, 8'd0);
      tbl[1] = mk(8'h99, 2'd0, pack4(66,128,192,256), pack4(240,240,240,240), 4'b0, 8'd0);
      tbl[2] = mk(8'h1A, 2'd1, pack4(67,128,192,256), pack4(240,239,240,240), 4'b0, 8'd0);
      tbl[3] = mk(8'h04, 2'd2, pack4(68,128,191,256), pack4(240,238,240,240), 4'b0, 8'd0);
      tbl[4] = mk(8'h16, 2'd3, pack4(69,128,190,256), pack4(240,237,240,241), 4'b0, 8'd0);
      tbl[5] = mk(8'h16, 2'd0, pack4(69,128,189,256), pack4(241,236,240,242), 4'b0, 8'd0);

      // Reset values
      repeat (3) @(negedge Clk);
      chk("rst_spritex", SpriteX, pack4(64,128,192,256));
      chk("rst_spritey", SpriteY, pack4(240,240,240,240));
      chk("rst_busy", busy, 0);
      chk("rst_hit", hit, 0);
      chk("rst_hit_count", hit_count, 0);
      chk("sprite_size", SpriteS, 4);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      model_reset();

      // Table of hand-derived frames
      for (int i = 0; i < 6; i++) begin
         void'(model_frame(tbl[i].key, tbl[i].s));
         send_frame(tbl[i].key, tbl[i].s, tbl[i].e);
      end

      // Two synchronised edges two clocks apart give exactly one frame
      keycode = 8'h07;
      sel = 2'd0;
      sb_q.push_back(model_frame(8'h07, 0));
      @(negedge Clk); frame_clk = 1'b1;
      @(negedge Clk); frame_clk = 1'b0;
      @(negedge Clk); frame_clk = 1'b1;
      n = 0;
      while (!busy && n < 20) begin @(negedge Clk); n++; end
      chk("dbl_busy_rise", busy, 1);
      n = 0;
      while (busy && n < 40) begin @(negedge Clk); n++; end
      chk("dbl_busy_len", n, 5);
      extra = 0;
      repeat (10) begin @(negedge Clk); if (busy) extra++; end
      chk("dbl_second_tick_dropped", extra, 0);
      check_output();
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);

      // Reset while sprite 2 is being processed
      do_reset();
      send_frame(8'h07, 2'd0, model_frame(8'h07, 0));
      keycode = 8'h07;
      sel = 2'd0;
      @(negedge Clk); frame_clk = 1'b1;
      n = 0;
      while (!busy && n < 20) begin @(negedge Clk); n++; end
      chk("abort_busy_rise", busy, 1);
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      #1;
      chk("abort_spritex", SpriteX, pack4(64,128,192,256));
      chk("abort_spritey", SpriteY, pack4(240,240,240,240));
      chk("abort_busy", busy, 0);
      chk("abort_hit", hit, 0);
      chk("abort_hit_count", hit_count, 0);
      frame_clk = 1'b0;
      do_reset();
      send_frame(8'h04, 2'd1, model_frame(8'h04, 1));

      // Bottom-edge bounce
      do_reset();
      y_prev = 0; y_cur = 0; y_max = 0;
      for (int f = 0; f < 300; f++) begin
         send_frame(8'h16, 2'd0, model_frame(8'h16, 0));
         y_prev = y_cur;
         y_cur = int'(SpriteY[9:0]);
         if (y_cur > y_max) y_max = y_cur;
      end
      chk("bounce_y_max", y_max, 475);
      chk("bounce_y_last", y_cur, 474);
      chk("bounce_y_prev", y_prev, 475);

      // Collision onset counted once
      do_reset();
      for (int f = 0; f < 56; f++) send_frame(8'h07, 2'd0, model_frame(8'h07, 0));
      chk("col_x0", SpriteX[9:0], 120);
      chk("col_hit", hit, 4'b0010);
      chk("col_count", hit_count, 1);
      for (int f = 0; f < 5; f++) send_frame(8'h07, 2'd0, model_frame(8'h07, 0));
      chk("col_x0_later", SpriteX[9:0], 125);
      chk("col_count_held", hit_count, 1);

      chk("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
